// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write-back path.
package rf_pkg;

   localparam int XLEN   = 64;
   localparam int REG_AW = 5;

   typedef struct packed {
      logic [REG_AW-1:0] addr;
      logic [XLEN-1:0]   data;
   } wb_entry_t;

   // x0 is hardwired to zero: writes to it are dropped, lookups of it never hit.
   function automatic logic is_x0(input logic [REG_AW-1:0] a);
      return a == '0;
   endfunction

endpackage

// File: rtl/rf_wb_bypass.sv
// Priority lookup of one register address across the pending write-back entries.
// Entry 0 is the youngest; the highest index is the oldest.
import rf_pkg::*;

module rf_wb_bypass #(
   parameter int N = 5
) (
   input  logic [REG_AW-1:0] byp_addr,
   input  wb_entry_t [N-1:0] ent,
   input  logic [N-1:0]      ent_vld,
   output logic              hit,
   output logic [XLEN-1:0]   data
);

   // Scan oldest to youngest so the youngest match is the one left standing.
   always_comb begin
      hit  = 1'b0;
      data = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (ent_vld[i] && (ent[i].addr == byp_addr) && !is_x0(byp_addr)) begin
            hit  = 1'b1;
            data = ent[i].data;
         end
      end
   end

endmodule

// File: rtl/rf_wb_queue.sv
// Write-side front end of the integer register file: two producers feed a small
// FIFO that drains one write per cycle, with two forwarding lookups into it.
module rf_wb_queue #(
   parameter int DEPTH = 4,
   parameter int XLEN  = rf_pkg::XLEN,
   parameter int AW    = rf_pkg::REG_AW
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       a_valid,
   output logic                       a_ready,
   input  logic [AW-1:0]              a_addr,
   input  logic [XLEN-1:0]            a_data,
   input  logic                       b_valid,
   output logic                       b_ready,
   input  logic [AW-1:0]              b_addr,
   input  logic [XLEN-1:0]            b_data,
   output logic                       wr_en,
   output logic [AW-1:0]              wr_addr,
   output logic [XLEN-1:0]            wr_data,
   input  logic [AW-1:0]              byp1_addr,
   output logic                       byp1_hit,
   output logic [XLEN-1:0]            byp1_data,
   input  logic [AW-1:0]              byp2_addr,
   output logic                       byp2_hit,
   output logic [XLEN-1:0]            byp2_data,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   rf_pkg::wb_entry_t mem [DEPTH];

   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic          rr;
   logic [CW-1:0] free;
   logic          pop;
   logic          contend;
   logic          push_a;
   logic          push_b;
   logic [1:0]    n_push;

   rf_pkg::wb_entry_t [DEPTH:0] byp_ent;
   logic [DEPTH:0]              byp_vld;

   // The head pops this cycle whenever the queue is non-empty, so its slot counts as free.
   always_comb begin
      free = CW'(DEPTH) - count + CW'(count != '0);
      pop  = (count != '0) && !flush;
   end

   // Acceptance: ready only toward a valid source; round-robin only on the last free slot.
   always_comb begin
      a_ready = 1'b0;
      b_ready = 1'b0;
      contend = 1'b0;
      if (rst && !flush) begin
         if (free >= CW'(2)) begin
            a_ready = a_valid;
            b_ready = b_valid;
         end else if (free == CW'(1)) begin
            if (a_valid && b_valid) begin
               contend = 1'b1;
               a_ready = !rr;
               b_ready = rr;
            end else begin
               a_ready = a_valid;
               b_ready = b_valid;
            end
         end
      end
   end

   // x0 results are accepted but never take a slot.
   always_comb begin
      push_a = a_ready && !rf_pkg::is_x0(a_addr);
      push_b = b_ready && !rf_pkg::is_x0(b_addr);
      n_push = {1'b0, push_a} + {1'b0, push_b};
   end

   // Pointers, occupancy and round-robin state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         rr    <= 1'b0;
      end else if (flush) begin
         head  <= tail;
         count <= '0;
         rr    <= 1'b0;
      end else begin
         if (pop) head <= head + PW'(1);
         tail  <= tail + PW'(n_push);
         count <= count - CW'(pop) + CW'(n_push);
         if (contend) rr <= ~rr;
      end
   end

   // FIFO storage; A goes in first so a same-cycle B is the younger entry.
   always_ff @(posedge clk) begin
      if (push_a) mem[tail] <= '{addr: a_addr, data: a_data};
      if (push_b) mem[push_a ? tail + PW'(1) : tail] <= '{addr: b_addr, data: b_data};
   end

   // Register-file write port; address/data hold when idle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
      end else begin
         wr_en <= pop;
         if (pop) begin
            wr_addr <= mem[head].addr;
            wr_data <= mem[head].data;
         end
      end
   end

   // Lay pending entries out youngest first, with the in-flight write as the oldest.
   always_comb begin
      byp_ent = '0;
      byp_vld = '0;
      for (int k = 0; k < DEPTH; k++) begin
         byp_ent[k] = mem[tail - PW'(k + 1)];
         byp_vld[k] = CW'(k) < count;
      end
      byp_ent[DEPTH] = '{addr: wr_addr, data: wr_data};
      byp_vld[DEPTH] = wr_en;
   end

   rf_wb_bypass #(.N(DEPTH + 1)) u_byp1 (
      .byp_addr (byp1_addr),
      .ent      (byp_ent),
      .ent_vld  (byp_vld),
      .hit      (byp1_hit),
      .data     (byp1_data)
   );

   rf_wb_bypass #(.N(DEPTH + 1)) u_byp2 (
      .byp_addr (byp2_addr),
      .ent      (byp_ent),
      .ent_vld  (byp_vld),
      .hit      (byp2_hit),
      .data     (byp2_data)
   );

endmodule

// File: tb/tb_rf_wb_queue.sv
// Directed bench for rf_wb_queue with hand-computed expectations.
module tb_rf_wb_queue;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        a_valid, a_ready, b_valid, b_ready;
   logic [4:0]  a_addr, b_addr;
   logic [63:0] a_data, b_data;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [63:0] wr_data;
   logic [4:0]  byp1_addr, byp2_addr;
   logic        byp1_hit, byp2_hit;
   logic [63:0] byp1_data, byp2_data;
   logic [2:0]  count;

   int checks   = 0;
   int failures = 0;

   logic [68:0] sb [$];
   logic [68:0] e;

   int exp_ar  [8]  = '{1, 1, 1, 1, 0, 1, 0, 1};
   int exp_br  [8]  = '{1, 1, 1, 0, 1, 0, 1, 0};
   int exp_cnt [13] = '{2, 3, 4, 4, 4, 4, 4, 4, 3, 2, 1, 0, 0};

   rf_wb_queue #(.DEPTH(4), .XLEN(64), .AW(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .a_valid   (a_valid),
      .a_ready   (a_ready),
      .a_addr    (a_addr),
      .a_data    (a_data),
      .b_valid   (b_valid),
      .b_ready   (b_ready),
      .b_addr    (b_addr),
      .b_data    (b_data),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .byp1_addr (byp1_addr),
      .byp1_hit  (byp1_hit),
      .byp1_data (byp1_data),
      .byp2_addr (byp2_addr),
      .byp2_hit  (byp2_hit),
      .byp2_data (byp2_data),
      .count     (count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      a_valid = 1'b0;
      b_valid = 1'b0;
      flush   = 1'b0;
   endtask

   task automatic push2(input logic [4:0] aa, input logic [63:0] ad,
                        input logic [4:0] ba, input logic [63:0] bd);
      a_valid = 1'b1; a_addr = aa; a_data = ad;
      b_valid = 1'b1; b_addr = ba; b_data = bd;
      tick();
      idle();
   endtask

   initial begin
      rst = 1'b0;
      flush = 1'b0;
      a_valid = 1'b1; a_addr = 5'd3; a_data = 64'h1;
      b_valid = 1'b0; b_addr = 5'd0; b_data = 64'h0;
      byp1_addr = 5'd3; byp2_addr = 5'd0;
      tick();
      tick();
      chk("rst_a_ready", a_ready, 0);
      chk("rst_count", count, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_byp1_hit", byp1_hit, 0);
      rst = 1'b1;
      idle();
      tick();

      // Single push through an empty queue
      a_valid = 1'b1; a_addr = 5'd5; a_data = 64'h11;
      byp1_addr = 5'd5; byp2_addr = 5'd6;
      #1;
      chk("t1_a_ready", a_ready, 1);
      chk("t1_byp1_hit_pre", byp1_hit, 0);
      tick();
      idle();
      #1;
      chk("t1_count", count, 1);
      chk("t1_wr_en0", wr_en, 0);
      chk("t1_byp1_hit_q", byp1_hit, 1);
      chk("t1_byp1_data_q", byp1_data, 64'h11);
      chk("t1_byp2_hit", byp2_hit, 0);
      tick();
      chk("t1_wr_en1", wr_en, 1);
      chk("t1_wr_addr", wr_addr, 5);
      chk("t1_wr_data", wr_data, 64'h11);
      chk("t1_count0", count, 0);
      chk("t1_byp1_hit_wr", byp1_hit, 1);
      chk("t1_byp1_data_wr", byp1_data, 64'h11);
      tick();
      chk("t1_wr_en_done", wr_en, 0);
      chk("t1_wr_addr_hold", wr_addr, 5);
      chk("t1_byp1_hit_done", byp1_hit, 0);
      chk("t1_byp1_data_miss", byp1_data, 0);

      // Both producers every cycle: fill, then alternate on the last slot
      for (int i = 0; i < 13; i++) begin
         if (i < 8) begin
            a_valid = 1'b1; a_addr = 5'(1 + i);  a_data = 64'h100 + 64'(i);
            b_valid = 1'b1; b_addr = 5'(16 + i); b_data = 64'h200 + 64'(i);
         end else begin
            idle();
         end
         #1;
         if (i < 8) begin
            chk("t2_a_ready", a_ready, 64'(exp_ar[i]));
            chk("t2_b_ready", b_ready, 64'(exp_br[i]));
            if (exp_ar[i] != 0) sb.push_back({a_addr, a_data});
            if (exp_br[i] != 0) sb.push_back({b_addr, b_data});
         end
         tick();
         chk("t2_count", count, 64'(exp_cnt[i]));
         chk("t2_wr_en", wr_en, 64'((i >= 1) && (i <= 11)));
         if (wr_en && sb.size() > 0) begin
            e = sb.pop_front();
            chk("t2_wr_addr", wr_addr, 64'(e[68:64]));
            chk("t2_wr_data", wr_data, e[63:0]);
         end
      end
      chk("t2_sb_left", 64'(sb.size()), 0);

      // Same destination from both producers in one cycle
      byp1_addr = 5'd7; byp2_addr = 5'd7;
      a_valid = 1'b1; a_addr = 5'd7; a_data = 64'hAA;
      b_valid = 1'b1; b_addr = 5'd7; b_data = 64'hBB;
      #1;
      chk("t3_a_ready", a_ready, 1);
      chk("t3_b_ready", b_ready, 1);
      tick();
      idle();
      #1;
      chk("t3_count", count, 2);
      chk("t3_byp1_data", byp1_data, 64'hBB);
      chk("t3_byp2_hit", byp2_hit, 1);
      tick();
      chk("t3_wr0_data", wr_data, 64'hAA);
      chk("t3_byp_after0", byp1_data, 64'hBB);
      tick();
      chk("t3_wr1_en", wr_en, 1);
      chk("t3_wr1_data", wr_data, 64'hBB);
      chk("t3_count0", count, 0);
      tick();
      chk("t3_wr_en_done", wr_en, 0);

      // x0 write: accepted, never stored or written
      byp1_addr = 5'd0;
      a_valid = 1'b1; a_addr = 5'd0; a_data = 64'hFF;
      #1;
      chk("t4_a_ready", a_ready, 1);
      chk("t4_byp_hit", byp1_hit, 0);
      tick();
      idle();
      chk("t4_count", count, 0);
      chk("t4_byp_data", byp1_data, 0);
      tick();
      chk("t4_wr_en", wr_en, 0);

      // Flush with three queued and one in flight
      push2(5'd1, 64'h1, 5'd2, 64'h2);
      push2(5'd3, 64'h3, 5'd4, 64'h4);
      chk("t5_count3", count, 3);
      chk("t5_wr_en", wr_en, 1);
      flush = 1'b1;
      a_valid = 1'b1; a_addr = 5'd9;  a_data = 64'h9;
      b_valid = 1'b1; b_addr = 5'd10; b_data = 64'hA;
      byp1_addr = 5'd3; byp2_addr = 5'd1;
      #1;
      chk("t5_a_ready_fl", a_ready, 0);
      chk("t5_b_ready_fl", b_ready, 0);
      chk("t5_wr_addr_fl", wr_addr, 1);
      chk("t5_byp1_pre", byp1_data, 64'h3);
      tick();
      idle();
      #1;
      chk("t5_count0", count, 0);
      chk("t5_wr_en0", wr_en, 0);
      chk("t5_byp1_hit", byp1_hit, 0);
      chk("t5_byp2_hit", byp2_hit, 0);

      // Asynchronous reset mid-drain, then normal operation
      push2(5'd1, 64'h1, 5'd2, 64'h2);
      push2(5'd3, 64'h3, 5'd4, 64'h4);
      chk("t6_count3", count, 3);
      a_valid = 1'b1; a_addr = 5'd5; a_data = 64'h55;
      rst = 1'b0;
      #1;
      chk("t6_wr_en", wr_en, 0);
      chk("t6_count", count, 0);
      chk("t6_a_ready", a_ready, 0);
      rst = 1'b1;
      #1;
      chk("t6_a_ready_rel", a_ready, 1);
      tick();
      idle();
      chk("t6_count1", count, 1);
      tick();
      chk("t6_wr_en1", wr_en, 1);
      chk("t6_wr_addr", wr_addr, 5);
      chk("t6_wr_data", wr_data, 64'h55);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
